// File: rtl/l15_req_initiator_if.sv
// Core-side L1.5 transducer bus. The master modport is the initiator that
// issues requests and acknowledges returns; the slave modport is the L1.5.
interface l15_req_initiator_if #(
  parameter int DATA_W = 64
);
  // Request channel, initiator -> L1.5
  logic              transducer_l15_val;
  logic [4:0]        transducer_l15_rqtype;
  logic              transducer_l15_nc;
  logic [2:0]        transducer_l15_size;
  logic [39:0]       transducer_l15_address;
  logic [63:0]       transducer_l15_data;
  logic              transducer_l15_threadid;
  logic [3:0]        transducer_l15_amo_op;
  logic              transducer_l15_prefetch;
  logic              transducer_l15_blockstore;
  logic              transducer_l15_blockinitstore;
  logic              transducer_l15_invalidate_cacheline;
  logic [1:0]        transducer_l15_l1rplway;
  logic [63:0]       transducer_l15_data_next_entry;
  logic [32:0]       transducer_l15_csm_data;
  // Request accept, L1.5 -> initiator
  logic              l15_transducer_ack;
  logic              l15_transducer_header_ack;
  // Return channel, L1.5 -> initiator
  logic              l15_transducer_val;
  logic [3:0]        l15_transducer_returntype;
  logic [1:0]        l15_transducer_error;
  logic [DATA_W-1:0] l15_transducer_data;
  // Return acknowledge, initiator -> L1.5
  logic              transducer_l15_req_ack;

  modport master (
    output transducer_l15_val, transducer_l15_rqtype, transducer_l15_nc,
           transducer_l15_size, transducer_l15_address, transducer_l15_data,
           transducer_l15_threadid, transducer_l15_amo_op, transducer_l15_prefetch,
           transducer_l15_blockstore, transducer_l15_blockinitstore,
           transducer_l15_invalidate_cacheline, transducer_l15_l1rplway,
           transducer_l15_data_next_entry, transducer_l15_csm_data,
           transducer_l15_req_ack,
    input  l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
           l15_transducer_returntype, l15_transducer_error, l15_transducer_data
  );

  modport slave (
    input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_nc,
           transducer_l15_size, transducer_l15_address, transducer_l15_data,
           transducer_l15_threadid, transducer_l15_amo_op, transducer_l15_prefetch,
           transducer_l15_blockstore, transducer_l15_blockinitstore,
           transducer_l15_invalidate_cacheline, transducer_l15_l1rplway,
           transducer_l15_data_next_entry, transducer_l15_csm_data,
           transducer_l15_req_ack,
    output l15_transducer_ack, l15_transducer_header_ack, l15_transducer_val,
           l15_transducer_returntype, l15_transducer_error, l15_transducer_data
  );
endinterface

// File: rtl/l15_req_initiator.sv
// Single-outstanding load/store initiator on the L1.5 transducer interface.
// Handshake rule on every channel: a transfer happens in a cycle where valid
// and ready (or val and ack) are both high at the rising clock edge; the
// producer holds valid and its payload stable until that cycle.
// Every L1.5 return is acknowledged exactly once, one cycle after it is seen;
// returns that do not complete the outstanding request are counted and dropped.
module l15_req_initiator #(
  parameter int DATA_W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  // Client request
  input  logic        req_val,
  output logic        req_rdy,
  input  logic        req_we,
  input  logic        req_nc,
  input  logic [2:0]  req_size,
  input  logic [39:0] req_addr,
  input  logic [63:0] req_wdata,
  // Client response
  output logic        rsp_val,
  input  logic        rsp_rdy,
  output logic [63:0] rsp_data,
  output logic [1:0]  rsp_error,
  // Status
  output logic [7:0]  drop_cnt,
  output logic [1:0]  state_dbg,
  // L1.5 side
  l15_req_initiator_if.master l15
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RSP  = 2'd3
  } state_t;

  localparam logic [4:0] RQ_LOAD  = 5'b00000;
  localparam logic [4:0] RQ_STORE = 5'b00001;
  localparam logic [3:0] RT_LOAD  = 4'b0000;
  localparam logic [3:0] RT_STACK = 4'b0100;

  state_t      state;
  logic        we_q;
  logic        tl15_val_q;
  logic [4:0]  rqtype_q;
  logic        nc_q;
  logic [2:0]  size_q;
  logic [39:0] addr_q;
  logic [63:0] tdata_q;
  logic        rsp_val_q;
  logic [63:0] rsp_data_q;
  logic [1:0]  rsp_error_q;
  logic        req_ack_q;
  logic [7:0]  drop_cnt_q;

  logic [2:0]  size_eff;
  logic        ret_fire;
  logic        ret_match;

  // Sizes above 8B are not defined on this port; they behave as 8B.
  assign size_eff = req_size[2] ? 3'd3 : req_size;

  // Replicate right-aligned store data across the 64-bit data bus so the
  // L1.5 finds the bytes in whatever lane the address selects.
  function automatic logic [63:0] fmt_store(input logic [2:0] size, input logic [63:0] d);
    logic [63:0] r;
    case (size)
      3'd0:    r = {8{d[7:0]}};
      3'd1:    r = {4{d[15:0]}};
      3'd2:    r = {2{d[31:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  // A return is only looked at when we are not acking the previous one; the
  // L1.5 drops val in response to the ack, so that cycle carries nothing new.
  assign ret_fire  = l15.l15_transducer_val && !req_ack_q;
  assign ret_match = ret_fire && (state == WAIT) &&
                     (l15.l15_transducer_returntype == (we_q ? RT_STACK : RT_LOAD));

  // Request/response FSM with registered request fields and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      tl15_val_q  <= 1'b0;
      rqtype_q    <= '0;
      nc_q        <= 1'b0;
      size_q      <= '0;
      addr_q      <= '0;
      tdata_q     <= '0;
      rsp_val_q   <= 1'b0;
      rsp_data_q  <= '0;
      rsp_error_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_val) begin
            we_q       <= req_we;
            rqtype_q   <= req_we ? RQ_STORE : RQ_LOAD;
            nc_q       <= req_nc;
            size_q     <= size_eff;
            addr_q     <= req_addr;
            tdata_q    <= req_we ? fmt_store(size_eff, req_wdata) : 64'd0;
            tl15_val_q <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (l15.l15_transducer_ack) begin
            tl15_val_q <= 1'b0;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (ret_match) begin
            rsp_data_q  <= we_q ? 64'd0 : l15.l15_transducer_data[63:0];
            rsp_error_q <= l15.l15_transducer_error;
            rsp_val_q   <= 1'b1;
            state       <= RSP;
          end
        end
        RSP: begin
          if (rsp_rdy) begin
            rsp_val_q <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Acknowledge every return one cycle later and count the ones dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_ack_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      req_ack_q <= ret_fire;
      if (ret_fire && !ret_match && (drop_cnt_q != 8'hFF)) begin
        drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  assign req_rdy   = (state == IDLE);
  assign rsp_val   = rsp_val_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;
  assign drop_cnt  = drop_cnt_q;
  assign state_dbg = state;

  assign l15.transducer_l15_val                  = tl15_val_q;
  assign l15.transducer_l15_rqtype               = rqtype_q;
  assign l15.transducer_l15_nc                   = nc_q;
  assign l15.transducer_l15_size                 = size_q;
  assign l15.transducer_l15_address              = addr_q;
  assign l15.transducer_l15_data                 = tdata_q;
  assign l15.transducer_l15_threadid             = 1'b0;
  assign l15.transducer_l15_amo_op               = '0;
  assign l15.transducer_l15_prefetch             = 1'b0;
  assign l15.transducer_l15_blockstore           = 1'b0;
  assign l15.transducer_l15_blockinitstore       = 1'b0;
  assign l15.transducer_l15_invalidate_cacheline = 1'b0;
  assign l15.transducer_l15_l1rplway             = '0;
  assign l15.transducer_l15_data_next_entry      = '0;
  assign l15.transducer_l15_csm_data             = '0;
  assign l15.transducer_l15_req_ack              = req_ack_q;

endmodule

// File: tb/tb_l15_req_initiator.sv
// Directed bench for l15_req_initiator: loads, replicated stores, discards in
// WAIT and IDLE, drop counter saturation and reset in the middle of a request.
module tb_l15_req_initiator;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_val, req_rdy, req_we, req_nc;
  logic [2:0]  req_size;
  logic [39:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_val, rsp_rdy;
  logic [63:0] rsp_data;
  logic [1:0]  rsp_error;
  logic [7:0]  drop_cnt;
  logic [1:0]  state_dbg;

  l15_req_initiator_if #(.DATA_W(64)) l15_bus ();

  l15_req_initiator #(.DATA_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_val   (req_val),
    .req_rdy   (req_rdy),
    .req_we    (req_we),
    .req_nc    (req_nc),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_val   (rsp_val),
    .rsp_rdy   (rsp_rdy),
    .rsp_data  (rsp_data),
    .rsp_error (rsp_error),
    .drop_cnt  (drop_cnt),
    .state_dbg (state_dbg),
    .l15       (l15_bus)
  );

  // Scoreboard
  logic [63:0] exp_q[$];
  logic [1:0]  exp_err_q[$];
  int checks = 0;
  int errors = 0;
  int exp_drop = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Driver: client request, one-cycle handshake
  task automatic client_req(input logic we, input logic nc, input logic [2:0] size,
                            input logic [39:0] addr, input logic [63:0] wdata,
                            input bit push, input logic [63:0] exp_rsp, input logic [1:0] exp_err);
    int n = 0;
    while (!req_rdy && n < 50) begin
      step();
      n++;
    end
    check("req_rdy_before_req", req_rdy, 1'b1);
    req_val   = 1'b1;
    req_we    = we;
    req_nc    = nc;
    req_size  = size;
    req_addr  = addr;
    req_wdata = wdata;
    if (push) begin
      exp_q.push_back(exp_rsp);
      exp_err_q.push_back(exp_err);
    end
    step();
    req_val   = 1'b0;
    req_wdata = '0;
    req_addr  = '0;
    check("tl15_val_rise", l15_bus.transducer_l15_val, 1'b1);
    check("req_rdy_busy", req_rdy, 1'b0);
  endtask

  // Check the presented request fields against bench constants
  task automatic check_fields(input logic [4:0] rqtype, input logic nc, input logic [2:0] size,
                              input logic [39:0] addr, input logic [63:0] data);
    check("tl15_rqtype",  l15_bus.transducer_l15_rqtype,  rqtype);
    check("tl15_nc",      l15_bus.transducer_l15_nc,      nc);
    check("tl15_size",    l15_bus.transducer_l15_size,    size);
    check("tl15_address", l15_bus.transducer_l15_address, addr);
    check("tl15_data",    l15_bus.transducer_l15_data,    data);
  endtask

  // Driver: L1.5 accepts the request after some cycles
  task automatic l15_accept(input int delay);
    repeat (delay) begin
      check("tl15_val_hold", l15_bus.transducer_l15_val, 1'b1);
      step();
    end
    l15_bus.l15_transducer_ack = 1'b1;
    step();
    l15_bus.l15_transducer_ack = 1'b0;
    check("tl15_val_fall", l15_bus.transducer_l15_val, 1'b0);
  endtask

  // Driver: L1.5 presents one return; req_ack must pulse for exactly one cycle
  task automatic present_ret(input logic [3:0] rtype, input logic [63:0] data,
                             input logic [1:0] err, input bit exp_match);
    l15_bus.l15_transducer_val        = 1'b1;
    l15_bus.l15_transducer_returntype = rtype;
    l15_bus.l15_transducer_data       = data;
    l15_bus.l15_transducer_error      = err;
    step();
    l15_bus.l15_transducer_val = 1'b0;
    if (!exp_match) exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
    check("req_ack_pulse", l15_bus.transducer_l15_req_ack, 1'b1);
    check("rsp_val_after_ret", rsp_val, exp_match);
    check("drop_cnt", drop_cnt, exp_drop[7:0]);
    step();
    check("req_ack_low", l15_bus.transducer_l15_req_ack, 1'b0);
  endtask

  // Driver/monitor: accept the client response and score it
  task automatic collect_rsp();
    int n = 0;
    logic [63:0] e;
    logic [1:0]  ee;
    while (!rsp_val && n < 50) begin
      step();
      n++;
    end
    check("rsp_val_timeout", rsp_val, 1'b1);
    check("sb_pending", exp_q.size() != 0, 1'b1);
    if (exp_q.size() != 0) begin
      e  = exp_q.pop_front();
      ee = exp_err_q.pop_front();
      check("rsp_data", rsp_data, e);
      check("rsp_error", rsp_error, ee);
    end
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
    check("rsp_val_clear", rsp_val, 1'b0);
    check("req_rdy_after_rsp", req_rdy, 1'b1);
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Store table
  logic [2:0]  st_size [5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5};
  logic [2:0]  st_esize[5] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
  logic [63:0] st_wdata[5] = '{64'h0000_0000_0000_00AB, 64'h5555_0000_0000_BEEF,
                               64'h0000_0000_DEAD_BEEF, 64'h0123_4567_89AB_CDEF,
                               64'hFEDC_BA98_7654_3210};
  logic [63:0] st_edata[5] = '{64'hABAB_ABAB_ABAB_ABAB, 64'hBEEF_BEEF_BEEF_BEEF,
                               64'hDEAD_BEEF_DEAD_BEEF, 64'h0123_4567_89AB_CDEF,
                               64'hFEDC_BA98_7654_3210};
  logic [1:0]  st_err  [5] = '{2'd0, 2'd0, 2'd2, 2'd0, 2'd1};

  // Directed sequence
  initial begin
    logic [3:0] rtypes[4];
    rtypes = '{4'b0000, 4'b0100, 4'b0011, 4'b0111};
    rst_n = 1'b0;
    req_val = 1'b0; req_we = 1'b0; req_nc = 1'b0; req_size = '0;
    req_addr = '0; req_wdata = '0; rsp_rdy = 1'b0;
    l15_bus.l15_transducer_ack        = 1'b0;
    l15_bus.l15_transducer_header_ack = 1'b0;
    l15_bus.l15_transducer_val        = 1'b0;
    l15_bus.l15_transducer_returntype = '0;
    l15_bus.l15_transducer_error      = '0;
    l15_bus.l15_transducer_data       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_rdy",  req_rdy, 1'b1);
    check("rst_tl15_val", l15_bus.transducer_l15_val, 1'b0);
    check("rst_rsp_val",  rsp_val, 1'b0);
    check("rst_req_ack",  l15_bus.transducer_l15_req_ack, 1'b0);
    check("rst_drop_cnt", drop_cnt, 8'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    rst_n = 1'b1;
    step();

    // 8B load, ack 2 cycles after val, LOAD_RET 5 cycles later
    client_req(1'b0, 1'b0, 3'd3, 40'h00_8000_0040, 64'h0, 1'b1, 64'h1122_3344_5566_7788, 2'd0);
    check_fields(5'b00000, 1'b0, 3'd3, 40'h00_8000_0040, 64'h0);
    l15_accept(2);
    repeat (4) step();
    present_ret(4'b0000, 64'h1122_3344_5566_7788, 2'd0, 1'b1);
    collect_rsp();

    // Stores across all sizes, random L1.5 latencies
    for (int i = 0; i < 5; i++) begin
      client_req(1'b1, i[0], st_size[i], 40'h00_1000_0000 + 40'(i * 8), st_wdata[i],
                 1'b1, 64'd0, st_err[i]);
      check_fields(5'b00001, i[0], st_esize[i], 40'h00_1000_0000 + 40'(i * 8), st_edata[i]);
      l15_accept(int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 4)) step();
      present_ret(4'b0100, 64'hFFFF_FFFF_FFFF_FFFF, st_err[i], 1'b1);
      collect_rsp();
    end

    // Non-matching returns in WAIT are dropped, only the load data arrives
    client_req(1'b0, 1'b1, 3'd2, 40'h00_8000_0100, 64'h0, 1'b1, 64'hCAFE_F00D_0BAD_BEEF, 2'd0);
    l15_accept(0);
    present_ret(4'b0011, 64'h1111_1111_1111_1111, 2'd0, 1'b0);
    present_ret(4'b0111, 64'h2222_2222_2222_2222, 2'd0, 1'b0);
    present_ret(4'b0100, 64'h3333_3333_3333_3333, 2'd0, 1'b0);
    check("drop_cnt_wait", drop_cnt, 8'd3);
    present_ret(4'b0000, 64'hCAFE_F00D_0BAD_BEEF, 2'd0, 1'b1);
    collect_rsp();

    // Unsolicited returns while IDLE saturate the counter
    for (int i = 0; i < 300; i++) begin
      present_ret(rtypes[$urandom_range(0, 3)], 64'($urandom), 2'd0, 1'b0);
    end
    check("drop_cnt_sat", drop_cnt, 8'd255);
    check("req_rdy_idle", req_rdy, 1'b1);

    // Reset while the request is held in REQ without an ack
    client_req(1'b1, 1'b0, 3'd3, 40'h00_2000_0000, 64'h0123_4567_89AB_CDEF, 1'b0, 64'd0, 2'd0);
    step();
    check("tl15_val_pre_rst", l15_bus.transducer_l15_val, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tl15_val", l15_bus.transducer_l15_val, 1'b0);
    check("async_rst_req_rdy",  req_rdy, 1'b1);
    check("async_rst_drop_cnt", drop_cnt, 8'd0);
    exp_drop = 0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_req_rdy",  req_rdy, 1'b1);
    check("post_rst_drop_cnt", drop_cnt, 8'd0);
    check("post_rst_tl15_val", l15_bus.transducer_l15_val, 1'b0);
    check("post_rst_rsp_val",  rsp_val, 1'b0);

    // Recovery: one more load with an ack on the first request cycle
    client_req(1'b0, 1'b0, 3'd1, 40'h00_8000_0200, 64'h0, 1'b1, 64'h0000_0000_0000_5A5A, 2'd3);
    l15_accept(0);
    present_ret(4'b0000, 64'h0000_0000_0000_5A5A, 2'd3, 1'b1);
    collect_rsp();

    check("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
